tri_point_classifier: RTL
=========================

Name: tri_point_classifier

Overview:
- Iterative point-in-triangle classifier, parametrised in coordinate width, edge mode and counter width.
- A triangle is loaded once over a valid/ready handshake. Query points then stream in over a second handshake.
- Each point is tested with one shared cross-product unit, one edge per cycle. Results leave over a third handshake.
- Sits between the coordinate ROM/sequencer and the result consumer. Replaces the combinational three-instance sign comparison with a resettable, backpressured datapath.

Parameters:
- COORD_W, 12, width of each unsigned coordinate.
- EDGE_INCLUSIVE, 1, 1 = points on an edge or vertex count as inside; 0 = strict interior only.
- CNT_W, 8, width of the point index and inside counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- tri_valid  in  1  triangle vertices valid.
- tri_ready  out  1  triangle accepted when tri_valid & tri_ready.
- tri_p1x, tri_p1y, tri_p2x, tri_p2y, tri_p3x, tri_p3y  in  COORD_W each  vertices, unsigned.
- pt_valid  in  1  query point valid.
- pt_ready  out  1  point accepted when pt_valid & pt_ready.
- ptx, pty  in  COORD_W each  query point, unsigned.
- res_valid  out  1  result valid.
- res_ready  in  1  consumer accepts the result.
- res_inside  out  1  point classified inside.
- res_edge  out  1  at least one edge cross product is exactly zero, with no opposing signs.
- res_degen  out  1  loaded triangle has zero area.
- res_idx  out  CNT_W  sequence number of the point since the last triangle load, starting at 0.
- inside_count  out  CNT_W  number of inside results since the last triangle load; saturates at all-ones.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; res_valid, res_inside, res_edge, res_degen = 0; res_idx = 0; inside_count = 0; stored vertices cleared. Any in-flight point is discarded.
- States: IDLE, TRI_CHK, READY, E0, E1, E2, RESULT.
- IDLE: tri_ready=1, pt_ready=0. On tri accept: latch vertices, go to TRI_CHK.
- TRI_CHK: one cycle. Compute area = (p2x-p1x)*(p3y-p1y) - (p2y-p1y)*(p3x-p1x) and store degen = (area==0). Reset point index and inside_count to 0. Go to READY.
- READY: tri_ready=1. pt_ready = ~tri_valid, so a triangle load wins over a point in the same cycle. On point accept: latch ptx and pty, go to E0.
- Edge cross product, with a = first vertex and b = second vertex of the edge: d = (ptx-bx)*(ay-by) - (ax-bx)*(pty-by).
- E0 evaluates edge (p1,p2), E1 evaluates (p2,p3), E2 evaluates (p3,p1). Each stores pos=(d>0) and neg=(d<0).
- Arithmetic: differences are zero-extended to COORD_W+1 and formed as signed values. Products are 2*(COORD_W+1) signed. d is 2*(COORD_W+1)+1 signed. No overflow for any input.
- Classification, computed at the end of E2:
  - any_pos = OR of the three pos flags; any_neg = OR of the three neg flags; any_zero = at least one d==0.
  - inside (EDGE_INCLUSIVE=1) = ~degen & ~(any_pos & any_neg).
  - inside (EDGE_INCLUSIVE=0) = ~degen & ~any_zero & (all pos | all neg).
  - res_edge = ~degen & any_zero & ~(any_pos & any_neg), independent of mode.
  - Degenerate triangle: res_inside=0 and res_edge=0 always.
- RESULT: res_valid=1; outputs are held stable until res_ready. On the handshake:
  - res_valid drops;
  - the index increments, wrapping modulo 2^CNT_W;
  - inside_count increments if inside, saturating;
  - go to READY.
- Latency: point accepted at cycle T, res_valid=1 at T+4. Maximum throughput is one point per 5 cycles with res_ready tied high.
- tri_ready=0 and pt_ready=0 in TRI_CHK, E0–E2 and RESULT.
- inside_count and res_idx update in the same edge as the result handshake. inside_count is visible from the next cycle.

Test Plan:
- Reset → res_valid=0, tri_ready=1, pt_ready=0, inside_count=0. Assert rst_n low during E1 → IDLE immediately, no result emitted.
- Triangle (23,79),(15,68),(36,94), point (24,80) → at T+4: res_inside=1, res_edge=0, res_idx=0. After handshake inside_count=1.
- Same triangle, point (23,79) (vertex):
  - EDGE_INCLUSIVE=1 → inside=1, edge=1.
  - EDGE_INCLUSIVE=0 → inside=0, edge=1.
- Same triangle, points (84,72), (25,80), (200,134) → inside=0 each, res_idx=1,2,3, inside_count unchanged.
- Degenerate triangle (0,0),(10,10),(20,20), point (10,10) → res_degen=1, inside=0, edge=0. Hold res_ready=0 for 5 cycles → outputs stable, pt_ready=0.
- COORD_W=12 triangle (0,0),(4095,0),(0,4095):
  - point (4095,0) → inclusive inside=1, edge=1.
  - point (4095,4095) → inside=0.
  - tri_valid and pt_valid both high in READY → triangle accepted, point not accepted, counters cleared.

Source files
------------

// File: rtl/tri_point_classifier.sv
// Iterative point-in-triangle classifier.
// A triangle is loaded once. Query points are then tested one edge per cycle
// on a single shared cross-product unit. The same unit computes the triangle
// area in TRI_CHK. Results are held on a valid/ready output until consumed.
module tri_point_classifier #(
  parameter int COORD_W        = 12,
  parameter bit EDGE_INCLUSIVE = 1'b1,
  parameter int CNT_W          = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tri_valid,
  output logic               tri_ready,
  input  logic [COORD_W-1:0] tri_p1x,
  input  logic [COORD_W-1:0] tri_p1y,
  input  logic [COORD_W-1:0] tri_p2x,
  input  logic [COORD_W-1:0] tri_p2y,
  input  logic [COORD_W-1:0] tri_p3x,
  input  logic [COORD_W-1:0] tri_p3y,
  input  logic               pt_valid,
  output logic               pt_ready,
  input  logic [COORD_W-1:0] ptx,
  input  logic [COORD_W-1:0] pty,
  output logic               res_valid,
  input  logic               res_ready,
  output logic               res_inside,
  output logic               res_edge,
  output logic               res_degen,
  output logic [CNT_W-1:0]   res_idx,
  output logic [CNT_W-1:0]   inside_count
);

  // Signed difference width, product width and cross-product width.
  // These widths are wide enough that no input combination can overflow.
  localparam int DW = COORD_W + 1;
  localparam int PW = 2 * DW;
  localparam int XW = PW + 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    TRI_CHK = 3'd1,
    READY   = 3'd2,
    E0      = 3'd3,
    E1      = 3'd4,
    E2      = 3'd5,
    RESULT  = 3'd6
  } state_t;

  state_t state_reg, state_next;

  // Stored vertices (index 0..2 = p1..p3) and the query point under test.
  logic [COORD_W-1:0] vx_reg [3];
  logic [COORD_W-1:0] vy_reg [3];
  logic [COORD_W-1:0] qx_reg, qy_reg;
  logic               degen_reg;

  logic               res_valid_reg, res_inside_reg, res_edge_reg, res_degen_reg;
  logic [CNT_W-1:0]   idx_reg, cnt_reg;

  logic               tri_acc, pt_acc, res_acc;

  // Cross-product unit operands: d = (ux-bx)*(ay-by) - (ax-bx)*(uy-by).
  logic [COORD_W-1:0] ux, uy, ax, ay, bx, by;
  logic signed [DW-1:0] du_x, da_y, da_x, du_y;
  logic signed [PW-1:0] prod_l, prod_r;
  logic signed [XW-1:0] d_val;
  logic                 d_pos, d_neg, d_zero;

  // Per-edge sign flags captured in E0 and E1. E2 uses the live result.
  logic [1:0] pos_st, neg_st, zero_st;
  logic [2:0] pos_all, neg_all, zero_all;
  logic       any_pos, any_neg, any_zero, mixed;
  logic       inside_c, edge_c;

  function automatic logic signed [DW-1:0] sdiff(input logic [COORD_W-1:0] x,
                                                 input logic [COORD_W-1:0] y);
    return $signed({1'b0, x}) - $signed({1'b0, y});
  endfunction

  assign tri_acc = tri_valid & tri_ready;
  assign pt_acc  = pt_valid & pt_ready;
  assign res_acc = res_valid_reg & res_ready;

  // Next-state and handshake-ready decode. A triangle load beats a point.
  always_comb begin
    state_next = state_reg;
    tri_ready  = 1'b0;
    pt_ready   = 1'b0;
    case (state_reg)
      IDLE: begin
        tri_ready = 1'b1;
        if (tri_valid) state_next = TRI_CHK;
      end
      TRI_CHK: state_next = READY;
      READY: begin
        tri_ready = 1'b1;
        pt_ready  = ~tri_valid;
        if (tri_valid)     state_next = TRI_CHK;
        else if (pt_valid) state_next = E0;
      end
      E0: state_next = E1;
      E1: state_next = E2;
      E2: state_next = RESULT;
      RESULT: begin
        if (res_ready) state_next = READY;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Operand selection. The area check reuses the edge formula with u=p2, a=p3, b=p1.
  always_comb begin
    ux = qx_reg;    uy = qy_reg;
    ax = vx_reg[0]; ay = vy_reg[0];
    bx = vx_reg[1]; by = vy_reg[1];
    case (state_reg)
      TRI_CHK: begin
        ux = vx_reg[1]; uy = vy_reg[1];
        ax = vx_reg[2]; ay = vy_reg[2];
        bx = vx_reg[0]; by = vy_reg[0];
      end
      E1: begin
        ax = vx_reg[1]; ay = vy_reg[1];
        bx = vx_reg[2]; by = vy_reg[2];
      end
      E2: begin
        ax = vx_reg[2]; ay = vy_reg[2];
        bx = vx_reg[0]; by = vy_reg[0];
      end
      default: ;
    endcase
  end

  // The shared cross-product unit. Operands are explicitly sign-extended
  // so each product is evaluated at full width.
  always_comb begin
    du_x   = sdiff(ux, bx);
    da_y   = sdiff(ay, by);
    da_x   = sdiff(ax, bx);
    du_y   = sdiff(uy, by);
    prod_l = $signed({{DW{du_x[DW-1]}}, du_x}) * $signed({{DW{da_y[DW-1]}}, da_y});
    prod_r = $signed({{DW{da_x[DW-1]}}, da_x}) * $signed({{DW{du_y[DW-1]}}, du_y});
    d_val  = $signed({prod_l[PW-1], prod_l}) - $signed({prod_r[PW-1], prod_r});
    d_zero = (d_val == '0);
    d_neg  = d_val[XW-1];
    d_pos  = ~d_val[XW-1] & ~d_zero;
  end

  // One flag register set per stored edge, written in that edge's cycle.
  for (genvar gi = 0; gi < 2; gi++) begin : g_edge_flags
    localparam state_t EDGE_ST = (gi == 0) ? E0 : E1;
    logic pos_r, neg_r, zero_r;
    // Capture the signs of this edge's cross product.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pos_r  <= 1'b0;
        neg_r  <= 1'b0;
        zero_r <= 1'b0;
      end else if (state_reg == EDGE_ST) begin
        pos_r  <= d_pos;
        neg_r  <= d_neg;
        zero_r <= d_zero;
      end
    end
    assign pos_st[gi]  = pos_r;
    assign neg_st[gi]  = neg_r;
    assign zero_st[gi] = zero_r;
  end

  // Final classification from the two stored edges plus the live third edge.
  always_comb begin
    pos_all  = {d_pos,  pos_st};
    neg_all  = {d_neg,  neg_st};
    zero_all = {d_zero, zero_st};
    any_pos  = |pos_all;
    any_neg  = |neg_all;
    any_zero = |zero_all;
    mixed    = any_pos & any_neg;
    if (EDGE_INCLUSIVE) inside_c = ~degen_reg & ~mixed;
    else                inside_c = ~degen_reg & ~any_zero & ((&pos_all) | (&neg_all));
    edge_c = ~degen_reg & any_zero & ~mixed;
  end

  // Vertex and query-point capture on their handshakes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        vx_reg[i] <= '0;
        vy_reg[i] <= '0;
      end
      qx_reg <= '0;
      qy_reg <= '0;
    end else begin
      if (tri_acc) begin
        vx_reg[0] <= tri_p1x; vy_reg[0] <= tri_p1y;
        vx_reg[1] <= tri_p2x; vy_reg[1] <= tri_p2y;
        vx_reg[2] <= tri_p3x; vy_reg[2] <= tri_p3y;
      end
      if (pt_acc) begin
        qx_reg <= ptx;
        qy_reg <= pty;
      end
    end
  end

  // Degeneracy flag, point index and saturating inside counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      degen_reg <= 1'b0;
      idx_reg   <= '0;
      cnt_reg   <= '0;
    end else if (state_reg == TRI_CHK) begin
      degen_reg <= d_zero;
      idx_reg   <= '0;
      cnt_reg   <= '0;
    end else if (state_reg == RESULT && res_acc) begin
      idx_reg <= idx_reg + 1'b1;
      if (res_inside_reg && (cnt_reg != {CNT_W{1'b1}}))
        cnt_reg <= cnt_reg + 1'b1;
    end
  end

  // Result registers: loaded at the end of E2, held until the handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_reg  <= 1'b0;
      res_inside_reg <= 1'b0;
      res_edge_reg   <= 1'b0;
      res_degen_reg  <= 1'b0;
    end else if (state_reg == E2) begin
      res_valid_reg  <= 1'b1;
      res_inside_reg <= inside_c;
      res_edge_reg   <= edge_c;
      res_degen_reg  <= degen_reg;
    end else if (res_acc) begin
      res_valid_reg <= 1'b0;
    end
  end

  assign res_valid    = res_valid_reg;
  assign res_inside   = res_inside_reg;
  assign res_edge     = res_edge_reg;
  assign res_degen    = res_degen_reg;
  assign res_idx      = idx_reg;
  assign inside_count = cnt_reg;

endmodule
